// File: rtl/axis_combiner_64x2to128.sv
// Pairs two 64-bit AXI4-Stream lanes into one 128-bit stream {B, A} through per-lane FIFOs.
// Define AXIS_COMBINER_LAST_CHECK_EN to enable the sticky/saturating A/B tlast mismatch monitor.
module axis_combiner_64x2to128 #(
   parameter int DEPTH = 4,
   parameter int ERRW  = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic [63:0]      s_axis_a_tdata,
   input  logic             s_axis_a_tvalid,
   output logic             s_axis_a_tready,
   input  logic             s_axis_a_tlast,
   input  logic [63:0]      s_axis_b_tdata,
   input  logic             s_axis_b_tvalid,
   output logic             s_axis_b_tready,
   input  logic             s_axis_b_tlast,
   output logic [127:0]     m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   input  logic             err_clr,
   output logic             last_err,
   output logic [ERRW-1:0]  last_err_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // Lane 0 is A, lane 1 is B; each word is {tlast, tdata}.
   logic [64:0]   fifo_mem [2][DEPTH];
   logic [AW-1:0] wr_ptr   [2];
   logic [AW-1:0] rd_ptr   [2];
   logic [CW-1:0] count    [2];
   logic [CW-1:0] count_nxt[2];
   logic [64:0]   s_word   [2];
   logic [1:0]    s_tvalid;
   logic [1:0]    rdy_q;
   logic [1:0]    push;
   logic [1:0]    not_empty;
   logic          pair;
   logic          out_valid;
   logic [64:0]   head_a;
   logic [64:0]   head_b;

   assign s_word[0] = {s_axis_a_tlast, s_axis_a_tdata};
   assign s_word[1] = {s_axis_b_tlast, s_axis_b_tdata};
   assign s_tvalid  = {s_axis_b_tvalid, s_axis_a_tvalid};
   assign push      = s_tvalid & rdy_q;
   assign s_axis_a_tready = rdy_q[0];
   assign s_axis_b_tready = rdy_q[1];

   assign head_a = fifo_mem[0][rd_ptr[0]];
   assign head_b = fifo_mem[1][rd_ptr[1]];
   assign pair   = (&not_empty) && (!out_valid || m_axis_tready);
   assign m_axis_tvalid = out_valid;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         not_empty[i] = (count[i] != '0);
         count_nxt[i] = count[i];
         case ({push[i], pair})
            2'b10:   count_nxt[i] = count[i] + CNT_ONE;
            2'b01:   count_nxt[i] = count[i] - CNT_ONE;
            default: count_nxt[i] = count[i];
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) fifo_mem[i][wr_ptr[i]] <= s_word[i];
      end
   end

   // Ready is registered from the next count, so it stays low through reset and rises one edge later.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rdy_q <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pair)    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            count[i] <= count_nxt[i];
            rdy_q[i] <= (count_nxt[i] != CNT_FULL);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid    <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tlast <= 1'b0;
      end else if (pair) begin
         out_valid    <= 1'b1;
         m_axis_tdata <= {head_b[63:0], head_a[63:0]};
         m_axis_tlast <= head_a[64] | head_b[64];
      end else if (m_axis_tready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef AXIS_COMBINER_LAST_CHECK_EN
   localparam logic [ERRW-1:0] ERR_ONE = ERRW'(1);
   logic mismatch;
   assign mismatch = pair && (head_a[64] != head_b[64]);

   // A mismatch on the same edge as a clear restarts the count at one rather than being lost.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         last_err     <= 1'b0;
         last_err_cnt <= '0;
      end else if (mismatch) begin
         last_err <= 1'b1;
         if (err_clr)
            last_err_cnt <= ERR_ONE;
         else if (last_err_cnt != '1)
            last_err_cnt <= last_err_cnt + ERR_ONE;
      end else if (err_clr) begin
         last_err     <= 1'b0;
         last_err_cnt <= '0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign last_err       = 1'b0;
   assign last_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_axis_combiner_64x2to128.sv
// Directed self-checking bench for axis_combiner_64x2to128 (DEPTH=4); follows AXIS_COMBINER_LAST_CHECK_EN.
module tb_axis_combiner_64x2to128;

`ifdef AXIS_COMBINER_LAST_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [63:0]   a_tdata, b_tdata;
   logic          a_tvalid, b_tvalid, a_tlast, b_tlast;
   logic          a_tready, b_tready;
   logic [127:0]  m_tdata;
   logic          m_tvalid, m_tready, m_tlast;
   logic          err_clr;
   logic          last_err;
   logic [15:0]   last_err_cnt;

   int total = 0;
   int bad   = 0;
   int na, nb;
   logic acc_a, acc_b;

   axis_combiner_64x2to128 #(.DEPTH(4), .ERRW(16)) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .s_axis_a_tdata  (a_tdata),
      .s_axis_a_tvalid (a_tvalid),
      .s_axis_a_tready (a_tready),
      .s_axis_a_tlast  (a_tlast),
      .s_axis_b_tdata  (b_tdata),
      .s_axis_b_tvalid (b_tvalid),
      .s_axis_b_tready (b_tready),
      .s_axis_b_tlast  (b_tlast),
      .m_axis_tdata    (m_tdata),
      .m_axis_tvalid   (m_tvalid),
      .m_axis_tready   (m_tready),
      .m_axis_tlast    (m_tlast),
      .err_clr         (err_clr),
      .last_err        (last_err),
      .last_err_cnt    (last_err_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [63:0] ad, input logic av, input logic al,
                                input logic [63:0] bd, input logic bv, input logic bl);
      a_tdata  = ad;
      a_tvalid = av;
      a_tlast  = al;
      b_tdata  = bd;
      b_tvalid = bv;
      b_tlast  = bl;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      aresetn  = 1'b0;
      m_tready = 1'b0;
      err_clr  = 1'b0;
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_a_tready", a_tready, 0);
      checkOutput("rst_b_tready", b_tready, 0);
      checkOutput("rst_tvalid", m_tvalid, 0);
      checkOutput("rst_tdata", m_tdata, 0);
      checkOutput("rst_tlast", m_tlast, 0);
      checkOutput("rst_last_err", last_err, 0);
      checkOutput("rst_err_cnt", last_err_cnt, 0);
      aresetn = 1'b1;
      #1;
      checkOutput("rel_a_tready_low", a_tready, 0);
      tick();
      checkOutput("rel_a_tready_high", a_tready, 1);
      checkOutput("rel_b_tready_high", b_tready, 1);

      $display("[TB] aligned stream");
      m_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(64'(i + 1), 1'b1, (i == 7), 64'(32'h100 + i), 1'b1, (i == 7));
         tick();
         if (i == 0) begin
            checkOutput("align_latency_tvalid", m_tvalid, 0);
         end else begin
            checkOutput("align_tvalid", m_tvalid, 1);
            checkOutput("align_tdata", m_tdata, {64'(32'h100 + i - 1), 64'(i)});
            checkOutput("align_tlast", m_tlast, 0);
         end
      end
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tick();
      checkOutput("align_last_tvalid", m_tvalid, 1);
      checkOutput("align_last_tdata", m_tdata, {64'h107, 64'h8});
      checkOutput("align_last_tlast", m_tlast, 1);
      tick();
      checkOutput("align_drain_tvalid", m_tvalid, 0);

      $display("[TB] skew");
      for (int i = 0; i < 4; i++) begin
         checkOutput("skew_a_tready_open", a_tready, 1);
         applyStimulus(64'(32'h11 + i), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      checkOutput("skew_a_tready_full", a_tready, 0);
      checkOutput("skew_b_tready", b_tready, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("skew_wait_tvalid", m_tvalid, 0);
      end
      for (int j = 0; j < 4; j++) begin
         applyStimulus(64'h0, 1'b0, 1'b0, 64'(32'h21 + j), 1'b1, 1'b0);
         tick();
         if (j == 0) begin
            checkOutput("skew_first_tvalid", m_tvalid, 0);
         end else begin
            checkOutput("skew_tvalid", m_tvalid, 1);
            checkOutput("skew_tdata", m_tdata, {64'(32'h21 + j - 1), 64'(32'h11 + j - 1)});
         end
      end
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tick();
      checkOutput("skew_last_tdata", m_tdata, {64'h24, 64'h14});
      checkOutput("skew_last_tvalid", m_tvalid, 1);
      tick();
      checkOutput("skew_drain_tvalid", m_tvalid, 0);

      $display("[TB] backpressure");
      m_tready = 1'b0;
      na = 0;
      nb = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(64'(32'h1000 + na), 1'b1, 1'b0, 64'(32'h2000 + nb), 1'b1, 1'b0);
         acc_a = a_tready;
         acc_b = b_tready;
         tick();
         if (acc_a) na++;
         if (acc_b) nb++;
         if (c >= 1) begin
            checkOutput("bp_hold_tvalid", m_tvalid, 1);
            checkOutput("bp_hold_tdata", m_tdata, {64'h2000, 64'h1000});
         end
      end
      checkOutput("bp_accepted_a", 128'(na), 5);
      checkOutput("bp_accepted_b", 128'(nb), 5);
      checkOutput("bp_a_tready", a_tready, 0);
      checkOutput("bp_b_tready", b_tready, 0);
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      m_tready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checkOutput("bp_rel_tvalid", m_tvalid, 1);
         checkOutput("bp_rel_tdata", m_tdata, {64'(32'h2000 + k), 64'(32'h1000 + k)});
         tick();
      end
      checkOutput("bp_drain_tvalid", m_tvalid, 0);

      $display("[TB] tlast mismatch");
      for (int p = 0; p < 4; p++) begin
         applyStimulus(64'(32'h30 + p), 1'b1, (p == 2), 64'(32'h40 + p), 1'b1, (p == 3));
         tick();
         if (p >= 1) begin
            checkOutput("mm_tdata", m_tdata, {64'(32'h40 + p - 1), 64'(32'h30 + p - 1)});
            checkOutput("mm_tlast", m_tlast, (p - 1 >= 2));
         end
      end
      checkOutput("mm_cnt_after_first", last_err_cnt, CHK ? 1 : 0);
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tick();
      checkOutput("mm_pair4_tlast", m_tlast, 1);
      checkOutput("mm_last_err", last_err, CHK ? 1 : 0);
      checkOutput("mm_err_cnt", last_err_cnt, CHK ? 2 : 0);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("clr_last_err", last_err, 0);
      checkOutput("clr_err_cnt", last_err_cnt, 0);
      applyStimulus(64'h50, 1'b1, 1'b1, 64'h60, 1'b1, 1'b0);
      tick();
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tick();
      checkOutput("pre_same_cnt", last_err_cnt, CHK ? 1 : 0);
      applyStimulus(64'h51, 1'b1, 1'b1, 64'h61, 1'b1, 1'b0);
      tick();
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("same_edge_tdata", m_tdata, {64'h61, 64'h51});
      checkOutput("same_edge_tlast", m_tlast, 1);
      checkOutput("same_edge_last_err", last_err, CHK ? 1 : 0);
      checkOutput("same_edge_cnt", last_err_cnt, CHK ? 1 : 0);
      tick();

      $display("[TB] reset mid-burst");
      m_tready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(64'(32'h70 + c), 1'b1, 1'b0, 64'(32'h80 + c), 1'b1, 1'b0);
         tick();
      end
      applyStimulus(64'h74, 1'b1, 1'b0, 64'h84, 1'b1, 1'b0);
      checkOutput("pre_rst_tvalid", m_tvalid, 1);
      #2;
      aresetn = 1'b0;
      #1;
      checkOutput("async_rst_tvalid", m_tvalid, 0);
      checkOutput("async_rst_a_tready", a_tready, 0);
      checkOutput("async_rst_b_tready", b_tready, 0);
      checkOutput("async_rst_tdata", m_tdata, 0);
      tick();
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      aresetn = 1'b1;
      tick();
      checkOutput("post_rst_a_tready", a_tready, 1);
      checkOutput("post_rst_b_tready", b_tready, 1);
      m_tready = 1'b1;
      applyStimulus(64'hA5A5, 1'b1, 1'b0, 64'hB5B5, 1'b1, 1'b0);
      tick();
      applyStimulus(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      checkOutput("post_rst_no_stale", m_tvalid, 0);
      tick();
      checkOutput("post_rst_tvalid", m_tvalid, 1);
      checkOutput("post_rst_tdata", m_tdata, {64'hB5B5, 64'hA5A5});
      tick();
      checkOutput("post_rst_drain", m_tvalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_combiner_64x2to128.md
# axis_combiner_64x2to128

Merges two independent 64-bit AXI4-Stream lanes (A, B) into one 128-bit stream. Lane A fills bits [63:0] and lane B fills bits [127:64]. It sits upstream of any 128-bit consumer that is fed by two 64-bit producers, and it is the inverse of the 128-to-64x2 split used on the source side. Each lane has its own FIFO, so A and B may present beats skewed in time. Output beats are formed only from one A beat paired with one B beat, in arrival order.

## Interface
- DEPTH, 4: entries per lane FIFO; power of two, minimum 2.
- ERRW, 16: width of the tlast-mismatch counter.

Ports:
- aclk  in  1  single clock; all logic is on its rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_a_tdata  in  64  lane A data.
- s_axis_a_tvalid  in  1  lane A valid.
- s_axis_a_tready  out  1  lane A ready.
- s_axis_a_tlast  in  1  lane A last.
- s_axis_b_tdata / _tvalid / _tready / _tlast: lane B, same widths and directions as lane A.
- m_axis_tdata  out  128  combined data, {B, A}.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- err_clr  in  1  single-cycle pulse; clears the error status.
- last_err  out  1  sticky flag: tlast mismatch seen.
- last_err_cnt  out  ERRW  saturating count of tlast mismatches.

## Operation
- **Lane FIFOs**
  - Each lane has a FIFO of DEPTH entries holding {tlast, tdata}.
  - Write on s_tvalid && s_tready.
  - s_axis_x_tready = !full_x, with the count registered. When a FIFO is full, ready is 0 and no push occurs.
- **Pairing**
  - A pop of both FIFOs ("pair") occurs at an edge when both FIFOs are non-empty AND (out_valid == 0 OR m_axis_tready == 1).
  - A and B always pop together. A single lane never pops alone.
- **Output register**
  - A pair loads m_axis_tdata = {B.data, A.data} and m_axis_tlast = A.last | B.last, and sets out_valid.
  - When m_axis_tready && out_valid and no pair occurs, out_valid clears.
  - Data, tlast and tvalid stay stable while tvalid=1 && tready=0.
- **FIFO behaviour**
  - Push and pop on the same edge leaves the count unchanged. This is legal on an empty FIFO only if the FIFO had data before the edge.
  - Pointers wrap modulo DEPTH. Full and empty are derived from a count of width log2(DEPTH)+1.
- **Reset**
  - Asserting aresetn mid-operation discards all FIFO contents and the output register immediately.
  - Reset values: s_axis_a_tready=0, s_axis_b_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, last_err=0, last_err_cnt=0.
  - Both s_tready signals rise on the first edge after aresetn deasserts.

## Timing
- **Latency:** a beat completing the pair at edge k appears as m_axis_tvalid=1 after edge k+1 (2 cycles), provided the output register is free.
- **Throughput:** one 128-bit beat per cycle when both lanes stream and m_axis_tready is held high.
- **Skew tolerance:** one lane may run up to DEPTH beats ahead of the other. After that, its tready drops until the slow lane catches up.
- **Backpressure:** m_axis_tready=0 stalls pairing. The FIFOs then fill, and tready drops DEPTH beats after the stall begins (for a lane that was empty at the start of the stall).

## Configuration
- **AXIS_COMBINER_LAST_CHECK_EN defined:**
  - On every pair where A.last != B.last, last_err is set and last_err_cnt increments, saturating at 2^ERRW-1.
  - err_clr clears both on the next edge. If err_clr and a mismatch occur on the same edge, the mismatch wins: last_err=1 and cnt=1.
- **AXIS_COMBINER_LAST_CHECK_EN not defined:**
  - The check logic is absent. last_err=0 and last_err_cnt=0 constantly, and err_clr is ignored.
  - m_axis_tlast is still A.last | B.last.

## Test plan
- **Aligned stream:** A=0x1..0x8 and B=0x100..0x107 driven every cycle, m_tready=1, tlast on the 8th beat of both lanes -> 8 output beats {0x100,0x1}..{0x107,0x8}, back-to-back. First tvalid 2 cycles after the first pair; tlast only on beat 8.
- **Skew:** 4 A beats first, then B beats 10 cycles later, DEPTH=4 -> s_axis_a_tready=0 after the 4th A beat. No output until B arrives, then 4 correctly ordered pairs.
- **Backpressure:** m_tready=0 for 20 cycles with both lanes streaming -> tdata and tvalid are held. Both treadys drop after DEPTH+1 accepted beats per lane (DEPTH FIFO entries plus the output register). No beat is lost or duplicated on release.
- **Mismatch (macro on):** A.last=1 with B.last=0 on pair 3, then a second mismatch -> last_err=1 and last_err_cnt=2. err_clr pulse -> both 0. Same-edge clear plus mismatch -> cnt=1.
- **Mismatch (macro off):** same stimulus -> last_err and last_err_cnt stay 0; m_axis_tlast=1 on pair 3.
- **Reset mid-burst:** aresetn pulled low with 3 entries in each FIFO and tvalid=1 -> tvalid=0 and both treadys 0 asynchronously. After release, the next pair output is new data only.
